// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC and holds each instruction for two execute cycles.
// Optional MISALIGN_TRAP_EN halts the stage on a misaligned jump target instead of aligning it.
module fetch_unit #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        j_signal,
  input  logic [31:0] jump,
  input  logic [31:0] imem_rdata,
  output logic [31:0] imem_addr,
  output logic [31:0] instr_out,
  output logic [31:0] pc_output,
  output logic        instr_valid,
  output logic        exec_phase,
  output logic        misaligned,
  output logic [31:0] instret
);

`ifdef MISALIGN_TRAP_EN
  typedef enum logic [2:0] {FETCH, LATCH, EXEC_B, EXEC_A, HALT} state_t;
`else
  typedef enum logic [1:0] {FETCH, LATCH, EXEC_B, EXEC_A} state_t;
`endif

  state_t      state, state_next;
  logic [31:0] pc, next_pc, pc_plus4, jump_target;
  logic        take_jump;

`ifdef MISALIGN_TRAP_EN
  logic bad_jump, misaligned_q, trap_pending;

  assign bad_jump    = j_signal && (jump[1:0] != 2'b00);
  assign take_jump   = j_signal && !bad_jump;
  assign jump_target = jump;
  assign misaligned  = misaligned_q;
`else
  assign take_jump   = j_signal;
  assign jump_target = jump & ~32'd3;
  assign misaligned  = 1'b0;
`endif

  assign pc_plus4   = pc + 32'd4;
  assign imem_addr  = pc;
  assign exec_phase = (state == EXEC_B);

  always_comb begin
    state_next = state;
    case (state)
      FETCH:  state_next = LATCH;
      LATCH:  state_next = EXEC_B;
      EXEC_B: state_next = EXEC_A;
`ifdef MISALIGN_TRAP_EN
      EXEC_A: state_next = trap_pending ? HALT : FETCH;
      HALT:   state_next = HALT;
`else
      EXEC_A: state_next = FETCH;
`endif
      default: state_next = FETCH;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state       <= FETCH;
      pc          <= RESET_PC;
      next_pc     <= RESET_PC;
      pc_output   <= RESET_PC;
      instr_out   <= NOP_INSTR;
      instr_valid <= 1'b0;
      instret     <= 32'd0;
`ifdef MISALIGN_TRAP_EN
      misaligned_q <= 1'b0;
      trap_pending <= 1'b0;
`endif
    end else if (!stall) begin
      state <= state_next;
      case (state)
        LATCH: begin
          instr_out   <= imem_rdata;
          pc_output   <= pc;
          instr_valid <= 1'b1;
        end
        EXEC_B: begin
          next_pc <= take_jump ? jump_target : pc_plus4;
`ifdef MISALIGN_TRAP_EN
          if (bad_jump) begin
            misaligned_q <= 1'b1;
            trap_pending <= 1'b1;
          end
`endif
        end
        EXEC_A: begin
          instr_out   <= NOP_INSTR;
          instr_valid <= 1'b0;
`ifdef MISALIGN_TRAP_EN
          // A trapped instruction does not retire and leaves the PC where it was.
          if (!trap_pending) begin
            pc      <= next_pc;
            instret <= instret + 32'd1;
          end
`else
          pc      <= next_pc;
          instret <= instret + 32'd1;
`endif
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed self-checking bench for fetch_unit; a second instance covers PC wraparound.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst, stall, j_signal;
  logic [31:0] jump, imem_rdata, imem_rdata2;
  logic [31:0] imem_addr, instr_out, pc_output, instret;
  logic        instr_valid, exec_phase, misaligned;
  logic [31:0] imem_addr2, instr_out2, pc_output2, instret2;
  logic        instr_valid2, exec_phase2, misaligned2;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  // Instruction memory model: each word is its own address tagged in the top nibble.
  assign imem_rdata  = imem_addr + 32'h1000_0000;
  assign imem_rdata2 = imem_addr2 + 32'h1000_0000;

  fetch_unit dut (
    .clk(clk), .rst(rst), .stall(stall), .j_signal(j_signal), .jump(jump),
    .imem_rdata(imem_rdata), .imem_addr(imem_addr), .instr_out(instr_out),
    .pc_output(pc_output), .instr_valid(instr_valid), .exec_phase(exec_phase),
    .misaligned(misaligned), .instret(instret)
  );

  fetch_unit #(.RESET_PC(32'hFFFF_FFFC)) dut_wrap (
    .clk(clk), .rst(rst), .stall(stall), .j_signal(j_signal), .jump(jump),
    .imem_rdata(imem_rdata2), .imem_addr(imem_addr2), .instr_out(instr_out2),
    .pc_output(pc_output2), .instr_valid(instr_valid2), .exec_phase(exec_phase2),
    .misaligned(misaligned2), .instret(instret2)
  );

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b0; stall = 1'b0; j_signal = 1'b0; jump = 32'd0;
    step(2);
    rst = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    n_checks++; if (imem_addr !== 32'd0) begin n_fail++; $display("[TB] FAIL reset_addr: got %h expected %h", imem_addr, 32'd0); end
    n_checks++; if (pc_output !== 32'd0) begin n_fail++; $display("[TB] FAIL reset_pc_output: got %h expected %h", pc_output, 32'd0); end
    n_checks++; if (instr_out !== 32'h13) begin n_fail++; $display("[TB] FAIL reset_instr: got %h expected %h", instr_out, 32'h13); end
    n_checks++; if (instr_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_valid: got %b expected 0", instr_valid); end
    n_checks++; if (exec_phase !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_phase: got %b expected 0", exec_phase); end
    n_checks++; if (misaligned !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_misaligned: got %b expected 0", misaligned); end
    n_checks++; if (instret !== 32'd0) begin n_fail++; $display("[TB] FAIL reset_instret: got %h expected 0", instret); end
    n_checks++; if (imem_addr2 !== 32'hFFFF_FFFC) begin n_fail++; $display("[TB] FAIL reset_addr_wrap: got %h expected fffffffc", imem_addr2); end
  endtask

  task automatic test_free_run();
    logic [31:0] e_pc, e_pc2;
    logic        e_valid, e_phase;
    do_reset();
    for (int c = 0; c < 12; c++) begin
      e_pc    = 32'(4 * (c / 4));
      e_pc2   = 32'hFFFF_FFFC + e_pc;
      e_phase = (c % 4 == 2);
      e_valid = (c % 4 == 2) || (c % 4 == 3);
      n_checks++; if (imem_addr !== e_pc) begin n_fail++; $display("[TB] FAIL run_addr c%0d: got %h expected %h", c, imem_addr, e_pc); end
      n_checks++; if (imem_addr2 !== e_pc2) begin n_fail++; $display("[TB] FAIL run_addr_wrap c%0d: got %h expected %h", c, imem_addr2, e_pc2); end
      n_checks++; if (exec_phase !== e_phase) begin n_fail++; $display("[TB] FAIL run_phase c%0d: got %b expected %b", c, exec_phase, e_phase); end
      n_checks++; if (instr_valid !== e_valid) begin n_fail++; $display("[TB] FAIL run_valid c%0d: got %b expected %b", c, instr_valid, e_valid); end
      if (e_valid) begin
        n_checks++; if (instr_out !== e_pc + 32'h1000_0000) begin n_fail++; $display("[TB] FAIL run_instr c%0d: got %h expected %h", c, instr_out, e_pc + 32'h1000_0000); end
        n_checks++; if (pc_output !== e_pc) begin n_fail++; $display("[TB] FAIL run_pc_output c%0d: got %h expected %h", c, pc_output, e_pc); end
      end else begin
        n_checks++; if (instr_out !== 32'h13) begin n_fail++; $display("[TB] FAIL run_nop c%0d: got %h expected %h", c, instr_out, 32'h13); end
      end
      step(1);
    end
    n_checks++; if (instret !== 32'd3) begin n_fail++; $display("[TB] FAIL run_instret: got %0d expected 3", instret); end
  endtask

  task automatic test_jump();
    do_reset();
    step(8);
    // Jump requests outside EXEC_B must be ignored.
    j_signal = 1'b1; jump = 32'h200;
    step(2);
    n_checks++; if (exec_phase !== 1'b1) begin n_fail++; $display("[TB] FAIL jump_phase: got %b expected 1", exec_phase); end
    jump = 32'h100;
    step(1);
    j_signal = 1'b1; jump = 32'h300;
    step(1);
    j_signal = 1'b0;
    n_checks++; if (imem_addr !== 32'h100) begin n_fail++; $display("[TB] FAIL jump_addr: got %h expected %h", imem_addr, 32'h100); end
    step(2);
    n_checks++; if (instr_valid !== 1'b1) begin n_fail++; $display("[TB] FAIL jump_valid: got %b expected 1", instr_valid); end
    n_checks++; if (pc_output !== 32'h100) begin n_fail++; $display("[TB] FAIL jump_pc_output: got %h expected %h", pc_output, 32'h100); end
    n_checks++; if (instr_out !== 32'h1000_0100) begin n_fail++; $display("[TB] FAIL jump_instr: got %h expected %h", instr_out, 32'h1000_0100); end
    n_checks++; if (instret !== 32'd3) begin n_fail++; $display("[TB] FAIL jump_instret: got %0d expected 3", instret); end
  endtask

  task automatic test_misaligned();
    logic        e_mis, e_valid;
    logic [31:0] e_ret;
`ifdef MISALIGN_TRAP_EN
    e_mis = 1'b1; e_valid = 1'b0; e_ret = 32'd3;
`else
    e_mis = 1'b0; e_valid = 1'b0; e_ret = 32'd4;
`endif
    // Continues from EXEC_B of the instruction at 0x100.
    j_signal = 1'b1; jump = 32'h102;
    step(1);
    j_signal = 1'b0;
    step(1);
    n_checks++; if (imem_addr !== 32'h100) begin n_fail++; $display("[TB] FAIL mis_addr: got %h expected %h", imem_addr, 32'h100); end
    n_checks++; if (misaligned !== e_mis) begin n_fail++; $display("[TB] FAIL mis_flag: got %b expected %b", misaligned, e_mis); end
    n_checks++; if (instret !== e_ret) begin n_fail++; $display("[TB] FAIL mis_instret: got %0d expected %0d", instret, e_ret); end
    step(2);
`ifdef MISALIGN_TRAP_EN
    e_valid = 1'b0;
`else
    e_valid = 1'b1;
`endif
    n_checks++; if (instr_valid !== e_valid) begin n_fail++; $display("[TB] FAIL mis_valid: got %b expected %b", instr_valid, e_valid); end
  endtask

  task automatic test_stall();
    do_reset();
    step(2);
    stall = 1'b1;
    // A jump pulse that is dropped before the stall lifts must not be taken.
    j_signal = 1'b1; jump = 32'h40;
    for (int i = 0; i < 5; i++) begin
      step(1);
      n_checks++; if (instr_out !== 32'h1000_0000) begin n_fail++; $display("[TB] FAIL stall_instr %0d: got %h expected %h", i, instr_out, 32'h1000_0000); end
      n_checks++; if (pc_output !== 32'd0) begin n_fail++; $display("[TB] FAIL stall_pc_output %0d: got %h expected 0", i, pc_output); end
      n_checks++; if (instret !== 32'd0) begin n_fail++; $display("[TB] FAIL stall_instret %0d: got %0d expected 0", i, instret); end
      n_checks++; if (exec_phase !== 1'b1) begin n_fail++; $display("[TB] FAIL stall_phase %0d: got %b expected 1", i, exec_phase); end
    end
    j_signal = 1'b0;
    step(1);
    stall = 1'b0;
    step(2);
    n_checks++; if (imem_addr !== 32'd4) begin n_fail++; $display("[TB] FAIL stall_resume_addr: got %h expected 4", imem_addr); end
    n_checks++; if (instret !== 32'd1) begin n_fail++; $display("[TB] FAIL stall_resume_instret: got %0d expected 1", instret); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    step(7);
    n_checks++; if (instret !== 32'd1) begin n_fail++; $display("[TB] FAIL mid_pre_instret: got %0d expected 1", instret); end
    rst = 1'b0; stall = 1'b1; j_signal = 1'b1; jump = 32'h80;
    step(1);
    n_checks++; if (imem_addr !== 32'd0) begin n_fail++; $display("[TB] FAIL mid_addr: got %h expected 0", imem_addr); end
    n_checks++; if (instr_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL mid_valid: got %b expected 0", instr_valid); end
    n_checks++; if (instret !== 32'd0) begin n_fail++; $display("[TB] FAIL mid_instret: got %0d expected 0", instret); end
    rst = 1'b1; stall = 1'b0; j_signal = 1'b0;
    step(4);
    n_checks++; if (imem_addr !== 32'd4) begin n_fail++; $display("[TB] FAIL mid_restart_addr: got %h expected 4", imem_addr); end
  endtask

  initial begin
    rst = 1'b0; stall = 1'b0; j_signal = 1'b0; jump = 32'd0;
    test_reset();
    test_free_run();
    test_jump();
    test_misaligned();
    test_stall();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
